// File: rtl/dmem_write_buffer_pkg.sv
// Shared constants and types for the data-memory posted-write buffer.
// The word-address helper is also what a DMEM model uses to index its array.
package dmem_write_buffer_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_PTR_W = 2;

  localparam int WA_HI = 31;
  localparam int WA_LO = 2;
  localparam int WA_W  = WA_HI - WA_LO + 1;

  typedef logic [WA_W-1:0] waddr_t;

  function automatic waddr_t word_addr(input logic [31:0] byte_addr);
    return byte_addr[WA_HI:WA_LO];
  endfunction

endpackage

// File: rtl/dmem_write_buffer_fwd_match.sv
// Store-to-load forwarding match: finds the youngest valid buffered store to
// the load's word address, scanning oldest-to-youngest from rd_ptr so wrap is handled.
module wbuf_fwd_match
  import dmem_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PTR_W = WB_PTR_W
) (
  input  logic [DEPTH-1:0] ent_valid,
  input  waddr_t           ent_addr [DEPTH],
  input  logic [31:0]      ent_data [DEPTH],
  input  waddr_t           cpu_word,
  input  logic [PTR_W-1:0] rd_ptr,
  input  logic [PTR_W:0]   count,
  output logic             hit,
  output logic [31:0]      hit_data
);

  always_comb begin
    logic [PTR_W-1:0] slot;
    // NOTE: every comb output gets a default before any conditional write, so no latch is inferred.
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    // Later ages overwrite earlier ones, leaving the youngest match.
    for (int age = 0; age < DEPTH; age++) begin
      slot = rd_ptr + PTR_W'(age);
      if (((PTR_W+1)'(age) < count) && ent_valid[slot] && (ent_addr[slot] == cpu_word)) begin
        hit      = 1'b1;
        hit_data = ent_data[slot];
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write buffer between the MEM-stage data port and the data-memory bus:
// stores queue in a FIFO that drains over req/ack, loads forward from it.
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PTR_W = WB_PTR_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wreq,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic        mem_wack,
  output logic        buf_full,
  output logic        buf_empty,
  output logic        overflow
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  waddr_t           ent_addr_q [DEPTH];
  waddr_t           ent_addr_d [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];

  logic        pop;
  logic        push;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == FULL_CNT);
  assign mem_wreq  = !buf_empty;
  assign mem_waddr = {ent_addr_q[rd_ptr_q], 2'b00};
  assign mem_wdata = ent_data_q[rd_ptr_q];
  assign mem_raddr = cpu_addr;
  assign overflow  = overflow_q;

  // A full buffer still accepts a store when the head leaves on the same edge.
  assign pop  = mem_wreq && mem_wack;
  assign push = cpu_we && (!buf_full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (cpu_we & ~push);
    valid_d    = valid_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_ONE;
    end
    // Push after pop: when full, wr_ptr equals rd_ptr and the new entry must win.
    if (push) begin
      valid_d[wr_ptr_q]    = 1'b1;
      ent_addr_d[wr_ptr_q] = word_addr(cpu_addr);
      ent_data_d[wr_ptr_q] = cpu_wdata;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  // NOTE: entry storage is not reset; valid_q and count_q gate every use of it.
  always_ff @(posedge clock) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

  wbuf_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd_match (
    .ent_valid (valid_q),
    .ent_addr  (ent_addr_q),
    .ent_data  (ent_data_q),
    .cpu_word  (word_addr(cpu_addr)),
    .rd_ptr    (rd_ptr_q),
    .count     (count_q),
    .hit       (fwd_hit),
    .hit_data  (fwd_data)
  );

  assign cpu_rdata = fwd_hit ? fwd_data : mem_rdata;

endmodule
